// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: default geometry,
// lane op codes and the sequencer state encoding.
package vec_pkg;
  localparam int VEC_LANES = 5;
  localparam int VEC_WIDTH = 32;

  localparam logic [2:0] VOP_ADD = 3'b000;
  localparam logic [2:0] VOP_SUB = 3'b001;
  localparam logic [2:0] VOP_AND = 3'b010;
  localparam logic [2:0] VOP_OR  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/vec_lane_alu.sv
// One combinational WIDTH-bit lane ALU with NZCV outputs.
// Any op with bit 2 set is a pass-through copy of a.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);
  logic             w_sub;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH:0]   w_sum;

  // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  assign w_sub = (op == VOP_SUB);
  assign w_bb  = w_sub ? ~b : b;
  assign w_sum = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    y = a;
    c = 1'b0;
    v = 1'b0;
    if (!op[2]) begin
      case (op[1:0])
        2'b00, 2'b01: begin
          y = w_sum[WIDTH-1:0];
          c = w_sum[WIDTH];
          v = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
        2'b10:   y = a & b;
        default: y = a | b;
      endcase
    end
  end

  assign n = y[WIDTH-1];
  assign z = (y == '0);
endmodule

// File: rtl/vec_lane_seq.sv
// Multicycle vector sequencer: captures a source vector and scalar, runs one
// shared lane ALU over the lanes one per cycle, then strobes the result out.
module vec_lane_seq
  import vec_pkg::*;
#(
  parameter int LANES = VEC_LANES,
  parameter int WIDTH = VEC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             ALUControl,
  input  logic [LANES*WIDTH-1:0] vec_in,
  input  logic [WIDTH-1:0]       imm32,
  input  logic [3:0]             vd,
  output logic                   busy,
  output logic                   stall,
  output logic                   done,
  output logic                   vec_we,
  output logic [3:0]             vec_wa,
  output logic [LANES*WIDTH-1:0] vec_out,
  output logic [3:0]             ALUFlags
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [LANES*WIDTH-1:0] r_src;
  logic [WIDTH-1:0]       r_imm;
  logic [2:0]             r_op;
  logic [3:0]             r_wa;
  logic [LANES*WIDTH-1:0] r_out;
  logic                   r_n, r_z, r_c, r_v;

  logic [WIDTH-1:0] w_a, w_y;
  logic             w_n, w_z, w_c, w_v;
  logic             w_accept;

  assign w_a = r_src[r_idx*WIDTH +: WIDTH];

  vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (w_a),
    .b  (r_imm),
    .op (r_op),
    .y  (w_y),
    .n  (w_n),
    .z  (w_z),
    .c  (w_c),
    .v  (w_v)
  );

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_src   <= '0;
      r_imm   <= '0;
      r_op    <= '0;
      r_wa    <= '0;
      r_out   <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_src   <= vec_in;
          r_imm   <= imm32;
          r_op    <= ALUControl;
          r_wa    <= vd;
          r_out   <= '0;
          r_idx   <= '0;
          r_n     <= 1'b0;
          r_z     <= 1'b0;
          r_c     <= 1'b0;
          r_v     <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_out[r_idx*WIDTH +: WIDTH] <= w_y;
          r_n <= r_n | w_n;
          r_c <= r_c | w_c;
          r_v <= r_v | w_v;
          // Z is an AND over lanes, so lane 0 seeds it instead of the cleared value.
          r_z <= (r_idx == '0) ? w_z : (r_z & w_z);
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
  assign stall    = w_accept || (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign vec_we   = done;
  assign vec_wa   = r_wa;
  assign vec_out  = r_out;
  assign ALUFlags = {r_n, r_z, r_c, r_v};
endmodule

// File: tb/tb_vec_lane_seq.sv
// Scoreboard bench for vec_lane_seq: expected results are queued at issue
// and compared when the write strobe appears.
module tb_vec_lane_seq;
  localparam int LANES = 5;
  localparam int WIDTH = 32;
  localparam int LW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    ALUControl = '0;
  logic [LW-1:0] vec_in = '0;
  logic [31:0]   imm32 = '0;
  logic [3:0]    vd = '0;
  logic          busy, stall, done, vec_we;
  logic [3:0]    vec_wa;
  logic [LW-1:0] vec_out;
  logic [3:0]    ALUFlags;

  typedef struct {
    logic [LW-1:0] vec;
    logic [3:0]    flags;
    logic [3:0]    wa;
    int            cyc;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  we_cnt = 0;

  vec_lane_seq #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .vec_in     (vec_in),
    .imm32      (imm32),
    .vd         (vd),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .vec_we     (vec_we),
    .vec_wa     (vec_wa),
    .vec_out    (vec_out),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model in signed/unsigned integer arithmetic, independent of the adder form.
  task automatic model(input logic [LW-1:0] v, input logic [31:0] b, input logic [2:0] op,
                       output logic [LW-1:0] res, output logic [3:0] fl);
    logic n, z, c, ov;
    n = 0; z = 1; c = 0; ov = 0;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [31:0] a, y;
      longint sr;
      a = v[i*WIDTH +: WIDTH];
      y = a;
      if (op == 3'b000) begin
        y = a + b;
        c |= ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sr = longint'($signed(a)) + longint'($signed(b));
        ov |= (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else if (op == 3'b001) begin
        y = a - b;
        c |= (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        ov |= (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end else if (op == 3'b010) y = a & b;
      else if (op == 3'b011) y = a | b;
      res[i*WIDTH +: WIDTH] = y;
      n |= y[31];
      z &= (y == 0);
    end
    fl = {n, z, c, ov};
  endtask

  always @(negedge clk) begin
    if (vec_we) begin
      we_cnt++;
      if (sb_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        sb_t it;
        it = sb_q.pop_front();
        chk("vec_out", vec_out, it.vec);
        chk("flags", LW'(ALUFlags), LW'(it.flags));
        chk("vec_wa", LW'(vec_wa), LW'(it.wa));
        chk("we_cycle", LW'(cyc), LW'(it.cyc));
      end
    end
  end

  function automatic logic [LW-1:0] mkvec(input logic [31:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic push_exp(input int t0);
    sb_t it;
    model(vec_in, imm32, ALUControl, it.vec, it.flags);
    it.wa  = vd;
    it.cyc = t0 + LANES + 1;
    sb_q.push_back(it);
  endtask

  task automatic run_op(input string nm, input logic [LW-1:0] v, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] d);
    int t0;
    sb_t it;
    @(posedge clk); #1;
    start = 1; vec_in = v; imm32 = b; ALUControl = op; vd = d;
    t0 = cyc;
    push_exp(t0);
    it = sb_q[sb_q.size()-1];
    for (int k = 0; k <= LANES + 2; k++) begin
      @(negedge clk);
      chk({nm, "_stall"}, LW'(stall), LW'(k <= LANES));
      chk({nm, "_busy"}, LW'(busy), LW'(k >= 1 && k <= LANES + 1));
      chk({nm, "_done"}, LW'(done), LW'(k == LANES + 1));
      if (k == LANES + 2) chk({nm, "_flags_held"}, LW'(ALUFlags), LW'(it.flags));
      @(posedge clk); #1;
      start = 0; vec_in = '1; imm32 = '1; ALUControl = 3'b111; vd = 4'hF;
    end
    chk({nm, "_sb_empty"}, LW'(sb_q.size()), 0);
  endtask

  initial begin
    int t0, w0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", LW'(busy), 0);
    chk("rst_stall", LW'(stall), 0);
    chk("rst_done", LW'(done), 0);
    chk("rst_we", LW'(vec_we), 0);
    chk("rst_wa", LW'(vec_wa), 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_flags", LW'(ALUFlags), 0);
    reset = 1;

    run_op("add", mkvec(1, 2, 3, 4, 5), 32'd10, 3'b000, 4'd3);
    run_op("sub", mkvec(7, 7, 7, 7, 0), 32'd7, 3'b001, 4'd9);
    run_op("ovf", mkvec(32'h7FFF_FFFF, 0, 0, 0, 0), 32'd1, 3'b000, 4'd1);
    run_op("and0", mkvec(32'hDEAD_BEEF, 1, 2, 32'hFFFF_FFFF, 8), 32'd0, 3'b010, 4'd4);
    run_op("or", mkvec(32'h10, 32'h8000_0000, 0, 5, 6), 32'h0F0F_0000, 3'b011, 4'd12);
    run_op("copy", mkvec(0, 0, 0, 0, 32'h1234), 32'hFFFF_FFFF, 3'b110, 4'd6);
    run_op("subbr", mkvec(32'h8000_0000, 3, 0, 1, 2), 32'd5, 3'b001, 4'd15);

    // Start held high: second op accepted only once the first has drained.
    @(posedge clk); #1;
    start = 1; vec_in = mkvec(9, 8, 7, 6, 5); imm32 = 32'd100; ALUControl = 3'b000; vd = 4'd2;
    t0 = cyc; w0 = we_cnt;
    push_exp(t0);
    push_exp(t0 + LANES + 2);
    for (int k = 0; k <= 2 * LANES + 5; k++) begin
      @(negedge clk);
      if (k == LANES + 1) chk("hold_stall_done", LW'(stall), 0);
      if (k == LANES + 2) chk("hold_stall_reacc", LW'(stall), 1);
      @(posedge clk); #1;
      if (k == LANES + 2) start = 0;
    end
    chk("hold_we_count", LW'(we_cnt - w0), 2);
    chk("hold_sb_empty", LW'(sb_q.size()), 0);

    // Reset in cycle 3 of a run: nothing may be written.
    @(posedge clk); #1;
    start = 1; vec_in = mkvec(1, 1, 1, 1, 1); imm32 = 32'd1; ALUControl = 3'b000; vd = 4'd5;
    w0 = we_cnt;
    @(posedge clk); #1; start = 0;
    repeat (2) @(posedge clk);
    #1; reset = 0;
    #1;
    chk("mid_busy", LW'(busy), 0);
    chk("mid_stall", LW'(stall), 0);
    chk("mid_done", LW'(done), 0);
    chk("mid_we", LW'(vec_we), 0);
    chk("mid_wa", LW'(vec_wa), 0);
    chk("mid_vec", vec_out, 0);
    chk("mid_flags", LW'(ALUFlags), 0);
    repeat (2) @(posedge clk);
    #1; reset = 1;
    repeat (LANES + 4) @(posedge clk);
    chk("mid_no_we", LW'(we_cnt - w0), 0);
    run_op("post", mkvec(32'hFFFF_FFFF, 20, 30, 40, 50), 32'd2, 3'b000, 4'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_lane_seq.md
# vec_lane_seq

Multicycle vector execution sequencer for the single-cycle ARM core's vector extension. It sits between the vector register file read port and its write port. It captures a 5-lane source vector and a 32-bit scalar operand, then runs one 32-bit lane ALU over the lanes, one lane per cycle. It then presents the full result vector with a one-cycle write strobe, and holds the PC stalled while it works.

## Interface
- `LANES`, default 5: number of 32-bit vector elements.
- `WIDTH`, default 32: element width in bits.
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: decoder request to execute a vector op; sampled only in IDLE.
- `ALUControl`, in, 3: op code.
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 1xx COPY: lane passes through unchanged.
- `vec_in`, in, LANES*WIDTH: source vector; lane i = bits [i*WIDTH +: WIDTH].
- `imm32`, in, WIDTH: scalar operand applied to every lane (lane op imm32).
- `vd`, in, 4: destination vector register address.
- `busy`, out, 1: high in RUN and DONE.
- `stall`, out, 1: PC hold. Combinationally high when IDLE and `start`=1; high throughout RUN; low in DONE.
- `done`, out, 1: one-cycle pulse in DONE.
- `vec_we`, out, 1: vector register file write enable; equals `done`.
- `vec_wa`, out, 4: captured `vd`.
- `vec_out`, out, LANES*WIDTH: result vector, registered.
- `ALUFlags`, out, 4: aggregate {N,Z,C,V}, registered; valid when `done`=1 and held until the next accepted start.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 at an edge captures `vec_in`, `imm32`, `ALUControl` and `vd`.
  - Clears `vec_out`, clears the flag accumulators, sets lane index to 0, and moves to RUN.
- **RUN**
  - Each edge computes lane[idx] = op(captured lane idx, captured imm) and writes it into `vec_out` lane idx.
  - The same edge merges that lane's flags, then increments idx.
  - The edge at idx = LANES-1 moves to DONE.
- **DONE:** `done`=`vec_we`=1 for exactly one cycle, then IDLE unconditionally.
- **Ignored starts:** `start` in RUN or DONE is ignored (not queued). Inputs other than `start` are don't-care outside the capture edge.
- **Lane arithmetic:** WIDTH-bit, wraps modulo 2^WIDTH.
  - SUB computes a + ~b + 1. C = carry-out (1 = no borrow, ARM convention).
  - V = signed overflow for ADD and SUB; 0 for AND, OR and COPY. C = 0 for AND, OR and COPY.
- **Aggregate flags:**
  - N = OR of lane MSBs.
  - Z = 1 iff every lane result is 0.
  - C = OR of lane carries.
  - V = OR of lane overflows.
- **Reset (asserted at any time, including mid-RUN):**
  - State returns to IDLE immediately and the partial operation is discarded; no write is issued.
  - Outputs: `busy`, `stall`, `done`, `vec_we` = 0; `vec_wa` = 0; `vec_out` = 0; `ALUFlags` = 0.

## Timing
- Cycle 0: `start`=1 in IDLE; `stall`=1 combinationally.
- Cycles 1..LANES: RUN, with lane i computed in cycle i+1. `stall`=`busy`=1.
- Cycle LANES+1 (6 with the default): DONE. `done`=`vec_we`=1, `vec_out` and `ALUFlags` are final, `stall`=0 so the PC advances on this edge.
- Cycle LANES+2: IDLE. The earliest next accepted `start` is sampled at the end of this cycle.
- Start-to-write latency: LANES+1 cycles; issue interval LANES+2 cycles.
- Unchanged lanes of `vec_out` read as 0 during RUN. Only the DONE-cycle value is architectural.

## Structure
- Package `vec_pkg` holds:
  - op code localparams (VOP_ADD, VOP_SUB, VOP_AND, VOP_OR);
  - the state enum {S_IDLE, S_RUN, S_DONE};
  - the default LANES and WIDTH values.
- Sub-module `vec_lane_alu` is combinational, one WIDTH-bit lane.
  - Inputs: a, b, op.
  - Outputs: y, n, z, c, v.
  - The sequencer instantiates it once and time-multiplexes it by lane index.
- Lane index counter width: $clog2(LANES).

## Test plan
- **ADD:** vec_in = {1,2,3,4,5}, imm32 = 10, op 000 → done in cycle 6, vec_out = {11,12,13,14,15}, vec_wa = vd, flags 0000; stall high in cycles 0–5 only.
- **SUB with zero and borrow:** vec_in = {7,7,7,7,0}, imm32 = 7, op 001 → lanes {0,0,0,0,0xFFFFFFF9}. Flags N=1, Z=0, C=1 (from the no-borrow lanes), V=0.
- **Overflow:** lane0 = 0x7FFFFFFF, other lanes 0, imm32 = 1, op 000 → lane0 = 0x80000000. Flags N=1, V=1, C=0, Z=0.
- **AND yielding all zero:** imm32 = 0, op 010 → vec_out all 0, flags Z=1, N=C=V=0.
- **Busy-start and restart:** `start` held high continuously → accepted only in cycles 0 and 7; exactly one `vec_we` pulse per op, in cycles 6 and 13.
- **Reset mid-RUN:** `reset` driven low in cycle 3 → all outputs 0 immediately, no `vec_we` pulse. After release, a new ADD completes with correct values.
